// File: rtl/gpio_input_conditioner.sv
// Two-flop synchronizer and per-bit debouncer for GPIO inputs, with optional sticky edge flags and irq.
// Build option: define GPIO_COND_EDGE_FLAGS_EN to compile the rise/fall flags and interrupt logic.
module gpio_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             io_mainClk,
  input  logic             io_asyncReset_n,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] stable_out,
  output logic             change_pulse,
  output logic [WIDTH-1:0] rise_mask,
  output logic [WIDTH-1:0] fall_mask,
  input  logic [WIDTH-1:0] mask_clr,
  input  logic [WIDTH-1:0] irq_en,
  output logic             irq
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic             r_change;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_stable_nxt;

  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pins_in;
      r_sync2 <= r_sync1;
    end
  end

  // A bit is accepted on the cycle its mismatch run reaches DEBOUNCE_CYCLES.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
    end
    w_stable_nxt = r_stable ^ w_accept;
  end

  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((r_sync2[i] == r_stable[i]) || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      r_stable <= '0;
      r_change <= 1'b0;
    end else begin
      r_stable <= w_stable_nxt;
      r_change <= |w_accept;
    end
  end

  assign stable_out   = r_stable;
  assign change_pulse = r_change;

`ifdef GPIO_COND_EDGE_FLAGS_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_irq;

  // Newly detected edges override a clear arriving on the same cycle.
  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      r_rise <= '0;
      r_fall <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_rise <= (r_rise & ~mask_clr) | (w_accept & w_stable_nxt);
      r_fall <= (r_fall & ~mask_clr) | (w_accept & r_stable);
      r_irq  <= |((r_rise | r_fall) & irq_en);
    end
  end

  assign rise_mask = r_rise;
  assign fall_mask = r_fall;
  assign irq       = r_irq;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = ^{mask_clr, irq_en};
  assign rise_mask    = '0;
  assign fall_mask    = '0;
  assign irq          = 1'b0;
`endif

endmodule

// File: doc/gpio_input_conditioner.md
GPIO_INPUT_CONDITIONER -- requirements
Module: gpio_input_conditioner

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of conditioned input bits.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable-mismatch cycles before a bit is accepted; legal range 1..65535.
REQ-003 SHALL have port io_mainClk  input  1  single clock for all state.
REQ-004 SHALL have port io_asyncReset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port pins_in  input  WIDTH  raw asynchronous switch/button levels.
REQ-006 SHALL have port stable_out  output  WIDTH  debounced levels, fed to the SoC gpioA read bus.
REQ-007 SHALL have port change_pulse  output  1  one-cycle strobe when any stable_out bit changes.
REQ-008 SHALL have port rise_mask  output  WIDTH  sticky per-bit rising-edge flags (macro-dependent).
REQ-009 SHALL have port fall_mask  output  WIDTH  sticky per-bit falling-edge flags (macro-dependent).
REQ-010 SHALL have port mask_clr  input  WIDTH  per-bit clear of rise_mask/fall_mask, write-1-to-clear, sampled each cycle.
REQ-011 SHALL have port irq_en  input  WIDTH  per-bit interrupt enable.
REQ-012 SHALL have port irq  output  1  registered OR of (rise_mask|fall_mask)&irq_en.

Function
REQ-013 SHALL pass each pins_in bit through a two-flop synchronizer (sync1, sync2); no other logic SHALL read pins_in.
REQ-014 SHALL keep per-bit counter cnt, width clog2(DEBOUNCE_CYCLES+1).
REQ-015 SHALL, per bit, when sync2 == stable_out: cnt <= 0.
REQ-016 SHALL, per bit, when sync2 != stable_out and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
REQ-017 SHALL, per bit, when sync2 != stable_out and cnt == DEBOUNCE_CYCLES-1: stable_out <= sync2, cnt <= 0.
REQ-018 SHALL give latency of exactly 2+DEBOUNCE_CYCLES clock edges from a clean pin change to stable_out update.
REQ-019 SHALL reject any glitch shorter than DEBOUNCE_CYCLES synchronized cycles; a return to the stable level at any point restarts the count from 0.
REQ-020 SHALL assert change_pulse for exactly the one cycle in which updated stable_out is first visible; several bits changing on the same edge SHALL give one pulse.
REQ-021 SHALL debounce bits independently; counters never share state.
REQ-022 SHALL, with DEBOUNCE_CYCLES == 1, accept a change on the first mismatched cycle (latency 3).

Reset
REQ-023 SHALL asynchronously clear sync1, sync2, cnt, stable_out, change_pulse, rise_mask, fall_mask and irq to 0 while io_asyncReset_n is low.
REQ-024 SHALL release reset synchronously to io_mainClk; a pin held high through reset SHALL appear on stable_out 2+DEBOUNCE_CYCLES edges after release, with rise_mask set for it.
REQ-025 SHALL discard any in-progress count on reset assertion mid-debounce.

Configuration
REQ-026 SHALL use macro GPIO_COND_EDGE_FLAGS_EN to compile the sticky edge-flag and interrupt logic.
REQ-027 SHALL, with GPIO_COND_EDGE_FLAGS_EN defined: set rise_mask[i] when stable_out[i] goes 0->1, fall_mask[i] when 1->0, both on the same edge as the stable_out update; clear on mask_clr[i]; set SHALL win over simultaneous clear; irq registered one cycle after the mask.
REQ-028 SHALL, without GPIO_COND_EDGE_FLAGS_EN: tie rise_mask, fall_mask and irq to 0, ignore mask_clr and irq_en, and instantiate no flag flops; debounce and change_pulse unchanged.

Verification
REQ-029 SHALL cover: DEBOUNCE_CYCLES=4, pins_in[0] 0->1 held -> stable_out[0]=1 exactly 6 edges later, change_pulse high 1 cycle, rise_mask=0x01, irq=1 next cycle with irq_en=0x01.
REQ-030 SHALL cover: DEBOUNCE_CYCLES=4, pins_in[3] high 3 cycles then low -> stable_out stays 0x00, no change_pulse, masks 0.
REQ-031 SHALL cover: pins_in 0x00->0x81 same cycle -> stable_out 0x81 after 6 edges, single change_pulse, rise_mask=0x81.
REQ-032 SHALL cover: rise_mask=0x01, mask_clr=0x01 asserted same cycle as new rise on bit 0 -> rise_mask stays 0x01; mask_clr alone next cycle -> 0x00, irq drops one cycle later.
REQ-033 SHALL cover: reset asserted with cnt=2 on bit 5 and pin held high -> outputs 0 immediately; after release stable_out[5]=1 after exactly 6 edges.
REQ-034 SHALL cover: build without GPIO_COND_EDGE_FLAGS_EN, toggle pins 0x00->0xFF->0x00 -> stable_out tracks with latency 6, rise_mask/fall_mask/irq constant 0.
